// File: rtl/alu_pkg.sv
// Shared opcode and FSM encodings for the sequential ALU.
package alu_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_NOT = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5,
    OP_SGT = 4'd6,
    OP_EQ  = 4'd7,
    OP_SLL = 4'd8,
    OP_SRA = 4'd9,
    OP_MUL = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier: first partial product is folded in on start,
// the remaining W-1 steps run one per cycle, and done pulses with the product.
module alu_mul_seq #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int SHW = $clog2(W);
  localparam int CW  = SHW + 1;

  logic [2*W-1:0] r_acc;
  logic [2*W-1:0] r_mcand;
  logic [W-1:0]   r_mplier;
  logic [CW-1:0]  r_cnt;
  logic           r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (start) begin
      r_acc    <= b[0] ? {{W{1'b0}}, a} : '0;
      r_mcand  <= {{(W-1){1'b0}}, a, 1'b0};
      r_mplier <= {1'b0, b[W-1:1]};
      r_cnt    <= CW'(W-1);
      r_busy   <= 1'b1;
    end else if (r_busy && (r_cnt != '0)) begin
      r_acc    <= r_acc + (r_mplier[0] ? r_mcand : '0);
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - {{(CW-1){1'b0}}, 1'b1};
    end else if (r_busy) begin
      r_busy   <= 1'b0;
    end
  end

  assign busy    = r_busy;
  assign done    = r_busy && (r_cnt == '0);
  assign product = r_acc;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes on both sides; single-cycle ops
// finish on the accept edge, MUL runs through the shift-add multiplier.
module alu_seq
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        a,
  input  logic [W-1:0]        b,
  input  logic [ALU_OP_W-1:0] op,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [W-1:0]        res,
  output logic                cf,
  output logic                of,
  output logic                zf,
  output logic                nf,
  output logic                err
);

  localparam int SHW = $clog2(W);

  alu_state_e r_state;
  logic [W-1:0] r_res;
  logic         r_cf, r_of, r_zf, r_nf, r_err;

  logic               w_accept, w_mulStart, w_mulBusy, w_mulDone;
  logic [2*W-1:0]     w_product;
  logic [SHW-1:0]     w_amt;
  logic [W:0]         w_sum, w_diff, w_sll;
  logic signed [W:0]  w_sra;
  logic [W-1:0]       w_res;
  logic               w_cf, w_of, w_err, w_zf, w_nf;
  logic               w_mulHigh;

  assign in_ready   = ((r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready)) && !w_mulBusy;
  assign w_accept   = in_valid && in_ready;
  assign w_mulStart = w_accept && (op == OP_MUL);

  alu_mul_seq #(.W(W)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (w_mulStart),
    .a       (a),
    .b       (b),
    .busy    (w_mulBusy),
    .done    (w_mulDone),
    .product (w_product)
  );

  // Shifts carry one extra bit so the last bit shifted out lands in cf.
  assign w_amt  = b[SHW-1:0];
  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
  assign w_sll  = {1'b0, a} << w_amt;
  assign w_sra  = $signed({a, 1'b0}) >>> w_amt;

  always_comb begin
    w_res = '0;
    w_cf  = 1'b0;
    w_of  = 1'b0;
    w_err = 1'b0;
    case (op)
      OP_ADD: begin
        w_res = w_sum[W-1:0];
        w_cf  = w_sum[W];
        w_of  = (a[W-1] == b[W-1]) && (w_sum[W-1] != a[W-1]);
      end
      OP_SUB: begin
        w_res = w_diff[W-1:0];
        w_cf  = w_diff[W];
        w_of  = (a[W-1] != b[W-1]) && (w_diff[W-1] != a[W-1]);
      end
      OP_NOT: w_res = ~a;
      OP_AND: w_res = a & b;
      OP_OR:  w_res = a | b;
      OP_XOR: w_res = a ^ b;
      OP_SGT: w_res = {{(W-1){1'b0}}, ($signed(a) > $signed(b))};
      OP_EQ:  w_res = {{(W-1){1'b0}}, (a == b)};
      OP_SLL: begin
        w_res = w_sll[W-1:0];
        w_cf  = w_sll[W];
      end
      OP_SRA: begin
        w_res = w_sra[W:1];
        w_cf  = w_sra[0];
      end
      OP_MUL: w_res = '0;
      default: w_err = 1'b1;
    endcase
  end

  // An illegal op reports res=0 but must not raise zf.
  assign w_zf      = !w_err && (w_res == '0);
  assign w_nf      = w_res[W-1];
  assign w_mulHigh = (w_product[2*W-1:W] != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_res   <= '0;
      r_cf    <= 1'b0;
      r_of    <= 1'b0;
      r_zf    <= 1'b0;
      r_nf    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            if (op == OP_MUL) begin
              r_state <= ST_MUL;
            end else begin
              r_state <= ST_DONE;
              r_res   <= w_res;
              r_cf    <= w_cf;
              r_of    <= w_of;
              r_zf    <= w_zf;
              r_nf    <= w_nf;
              r_err   <= w_err;
            end
          end else if ((r_state == ST_DONE) && out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        ST_MUL: begin
          if (w_mulDone) begin
            r_state <= ST_DONE;
            r_res   <= w_product[W-1:0];
            r_cf    <= w_mulHigh;
            r_of    <= w_mulHigh;
            r_zf    <= (w_product[W-1:0] == '0);
            r_nf    <= w_product[W-1];
            r_err   <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = (r_state == ST_DONE);
  assign res       = r_res;
  assign cf        = r_cf;
  assign of        = r_of;
  assign zf        = r_zf;
  assign nf        = r_nf;
  assign err       = r_err;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (W=8): directed cases plus random ops
// compared against an arithmetic reference model.
module tb_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic [3:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] res;
  logic         cf, of, zf, nf, err;
  logic [W+4:0] obsVec;

  int checks = 0;
  int errors = 0;

  alu_seq #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .cf        (cf),
    .of        (of),
    .zf        (zf),
    .nf        (nf),
    .err       (err)
  );

  always #5 clk = ~clk;

  assign obsVec = {err, cf, of, zf, nf, res};

  // Expected {err,cf,of,zf,nf,res} from signed/unsigned integer arithmetic.
  function automatic logic [W+4:0] refModel(input int opI, input int aI, input int bI);
    int sa, sb, r, c, o, amt, lim;
    longint p;
    logic [W-1:0] rr;
    lim = 2 ** (W - 1);
    sa  = (aI >= lim) ? aI - 2 ** W : aI;
    sb  = (bI >= lim) ? bI - 2 ** W : bI;
    r = 0; c = 0; o = 0;
    amt = bI % W;
    case (opI)
      0: begin r = aI + bI; c = int'(r >= 2 ** W); o = int'((sa + sb >= lim) || (sa + sb < -lim)); end
      1: begin r = aI - bI; c = int'(aI >= bI); o = int'((sa - sb >= lim) || (sa - sb < -lim)); end
      2: r = (2 ** W - 1) - aI;
      3: r = aI & bI;
      4: r = aI | bI;
      5: r = aI ^ bI;
      6: r = int'(sa > sb);
      7: r = int'(aI == bI);
      8: begin r = aI << amt; c = (amt != 0) ? ((aI >> (W - amt)) & 1) : 0; end
      9: begin r = sa >>> amt; c = (amt != 0) ? ((aI >> (amt - 1)) & 1) : 0; end
      10: begin
        p = longint'(aI) * longint'(bI);
        r = int'(p % (2 ** W));
        c = int'(p >= 2 ** W);
        o = c;
      end
      default: return {1'b1, 4'b0000, {W{1'b0}}};
    endcase
    r  = r & (2 ** W - 1);
    rr = r[W-1:0];
    return {1'b0, c[0], o[0], (rr == '0), rr[W-1], rr};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Issue one op, check latency and result, then optionally stall the consumer.
  task automatic applyStimulus(input logic [3:0] opIn, input logic [W-1:0] aIn,
                               input logic [W-1:0] bIn, input int hold, input string tag);
    logic [W+4:0] expVec;
    expVec = refModel(int'(opIn), int'(aIn), int'(bIn));
    @(negedge clk);
    checkOutput({tag, ":in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; op = opIn; a = aIn; b = bIn;
    @(posedge clk); #1;
    in_valid = 1'b0; a = W'($urandom); b = W'($urandom); op = 4'($urandom);
    if (opIn == 4'd10) begin
      for (int k = 0; k < W; k++) begin
        checkOutput({tag, ":mul_busy_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, ":mul_busy_ready"}, 32'(in_ready), 32'd0);
        @(posedge clk); #1;
      end
    end
    checkOutput({tag, ":out_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, ":result"}, 32'(obsVec), 32'(expVec));
    if (hold > 0) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        a = W'($urandom); b = W'($urandom); op = 4'($urandom);
        checkOutput({tag, ":hold_valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, ":hold_ready"}, 32'(in_ready), 32'd0);
        checkOutput({tag, ":hold_result"}, 32'(obsVec), 32'(expVec));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [W+4:0] e0, e1, e2;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; op = '0;
    #12;
    checkOutput("reset:out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset:outputs", 32'(obsVec), 32'd0);
    checkOutput("reset:in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(4'd0, 8'h7F, 8'h01, 0, "add_ovf");
    checkOutput("add_ovf:exact", 32'(obsVec), 32'({1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h80}));
    applyStimulus(4'd1, 8'h05, 8'h05, 0, "sub_zero");
    checkOutput("sub_zero:exact", 32'(obsVec), 32'({1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00}));
    applyStimulus(4'd1, 8'h80, 8'h01, 0, "sub_ovf");
    checkOutput("sub_ovf:exact", 32'(obsVec), 32'({1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h7F}));
    applyStimulus(4'd10, 8'h10, 8'h20, 0, "mul_hi");
    checkOutput("mul_hi:exact", 32'(obsVec), 32'({1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00}));
    applyStimulus(4'd9, 8'h90, 8'h0B, 0, "sra3");
    checkOutput("sra3:exact", 32'(obsVec), 32'({1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hF2}));
    applyStimulus(4'd6, 8'h01, 8'hFF, 0, "sgt");
    checkOutput("sgt:exact", 32'(res), 32'd1);
    applyStimulus(4'd12, 8'h33, 8'h44, 0, "illegal");
    checkOutput("illegal:exact", 32'(obsVec), 32'({1'b1, 4'b0000, 8'h00}));
    applyStimulus(4'd8, 8'hC3, 8'h00, 1, "sll0");
    applyStimulus(4'd10, 8'hFF, 8'hFF, 2, "mul_max");

    // Back-to-back AND/OR/XOR with the consumer always ready, then a stall.
    e0 = refModel(3, 8'hF0, 8'h3C);
    e1 = refModel(4, 8'h81, 8'h42);
    e2 = refModel(5, 8'hAA, 8'h0F);
    @(negedge clk);
    in_valid = 1'b1; op = 4'd3; a = 8'hF0; b = 8'h3C;
    @(negedge clk);
    checkOutput("b2b:and", 32'(obsVec), 32'(e0));
    checkOutput("b2b:and_ready", 32'(in_ready), 32'd1);
    op = 4'd4; a = 8'h81; b = 8'h42;
    @(negedge clk);
    checkOutput("b2b:or", 32'(obsVec), 32'(e1));
    checkOutput("b2b:or_valid", 32'(out_valid), 32'd1);
    op = 4'd5; a = 8'hAA; b = 8'h0F;
    @(negedge clk);
    checkOutput("b2b:xor", 32'(obsVec), 32'(e2));
    out_ready = 1'b0;
    op = 4'd0; a = 8'h11; b = 8'h22;
    for (int h = 0; h < 5; h++) begin
      @(negedge clk);
      checkOutput("stall:valid", 32'(out_valid), 32'd1);
      checkOutput("stall:ready", 32'(in_ready), 32'd0);
      checkOutput("stall:result", 32'(obsVec), 32'(e2));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("stall:retired", 32'(out_valid), 32'd0);

    // Reset in the fourth cycle of a multiply must abort it completely.
    @(negedge clk);
    in_valid = 1'b1; op = 4'd10; a = 8'h37; b = 8'h5A;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mulrst:out_valid", 32'(out_valid), 32'd0);
    checkOutput("mulrst:outputs", 32'(obsVec), 32'd0);
    checkOutput("mulrst:in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < W + 3; k++) begin
      @(negedge clk);
      checkOutput("mulrst:no_late_valid", 32'(out_valid), 32'd0);
    end

    for (int i = 0; i < 40; i++) begin
      applyStimulus(4'($urandom_range(0, 15)), W'($urandom), W'($urandom),
                    int'($urandom_range(0, 2)), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the team's 4-bit combinational ALU. Operands are accepted through a valid/ready input handshake; the result and flags are returned through a valid/ready output handshake. Single-cycle logic, arithmetic, compare and shift operations sit beside a multi-cycle unsigned multiply. The block sits between the operand register file and the result writeback in the lab datapath.

## Interface
- W, 8, operand/result width; power of two, 4 ≤ W ≤ 32
- SHW, $clog2(W), shift-amount width (derived, not overridable)

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands/opcode present
- in_ready  out  1  block can accept this cycle
- a, b  in  W  operands
- op  in  4  opcode
- out_valid  out  1  result registered and held
- out_ready  in  1  consumer takes result
- res  out  W  result
- cf, of, zf, nf  out  1  carry, overflow, zero, negative (res[W-1])
- err  out  1  illegal opcode flag

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 NOT a, 3 AND, 4 OR, 5 XOR, 6 SGT (res=1 iff a>b signed), 7 EQ (res=1 iff a==b), 8 SLL a by b[SHW-1:0], 9 SRA a by b[SHW-1:0], 10 MUL unsigned.
- Opcodes 11–15 are illegal: res=0, all flags 0, err=1. err=0 for every legal op.
- ADD: {cf,res}=a+b, W+1 bits; of=(a[W-1]==b[W-1])&&(res[W-1]!=a[W-1]).
- SUB: {cf,res}=a+~b+1; cf=1 means no borrow; of=(a[W-1]!=b[W-1])&&(res[W-1]!=a[W-1]).
- SLL/SRA: shift amount taken modulo W. cf is the last bit shifted out; cf=0 when the amount is 0. of=0.
- MUL: 2W-bit product; res=product[W-1:0]; cf=of=(product[2W-1:W]!=0).
- Logic, compare and NOT ops: cf=of=0.
- For every op: zf=(res==0) and nf=res[W-1].
- FSM states are IDLE, MUL, DONE.
  - IDLE, accept with a non-MUL op: result computed and registered; go to DONE.
  - IDLE, accept with MUL: operands captured; go to MUL.
  - MUL: one shift-add step per cycle. After exactly W steps, register the result; go to DONE.
  - DONE: out_valid=1; outputs held stable until out_ready=1.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This is a combinational path from out_ready to in_ready.
- When in_valid && in_ready in DONE, the new op is accepted and the old result retires in the same cycle. No bubble.
- Inputs a, b, op are sampled only on the accept edge. Changes at any other time are ignored.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE; out_valid=0; res=0; cf=of=zf=nf=err=0. in_ready=1 combinationally once in IDLE.
- Reset asserted mid-MUL or in DONE aborts the operation and discards the result. No out_valid follows.
- Non-MUL latency: accept on edge N → out_valid=1 after edge N, visible in cycle N+1.
- MUL latency: accept on edge N → out_valid=1 after edge N+W.
- Throughput:
  - Non-MUL: 1 op/cycle while out_ready=1.
  - MUL: 1 op per W+1 cycles.
- in_ready=0 throughout MUL, and in DONE while out_ready=0.
- out_valid never drops without out_ready=1 or reset.

## Structure
- Package alu_pkg holds:
  - opcode enum alu_op_e (values above)
  - FSM enum alu_state_e
  - constant ALU_OP_W=4
- Sub-module alu_mul_seq: W-parameterised shift-add multiplier.
  - Ports: clk, rst_n, start, a, b, busy, done, product[2W-1:0].
  - done pulses for one cycle when the product is valid.
- Top alu_seq contains the FSM, the combinational single-cycle datapath, and the output register.

## Test plan
1. W=8: ADD a=0x7F, b=0x01 → res=0x80, of=1, cf=0, nf=1, zf=0; out_valid one cycle after accept.
2. W=8: SUB a=0x05, b=0x05 → res=0x00, zf=1, cf=1, of=0. SUB a=0x80, b=0x01 → res=0x7F, of=1.
3. W=8: MUL a=0x10, b=0x20 → res=0x00, cf=of=1, zf=1; out_valid exactly 8 cycles after accept; in_ready=0 throughout.
4. W=8: SRA a=0x90 by b=0x0B (amount 3) → res=0xF2, cf=0. SGT a=0x01, b=0xFF → res=1.
5. Back-to-back AND, OR, XOR with out_ready tied 1 → three results on consecutive cycles. Then hold out_ready=0 for 5 cycles → res and flags stable, in_ready=0.
6. op=12 → err=1, res=0. Assert rst_n=0 at cycle 4 of a MUL → all outputs 0 immediately, in IDLE, no late out_valid.
